mlp_layer_sequencer: RTL and testbench

Control FSM that sequences a single shared multiply-accumulate (MAC) datapath through both MLP layers: 196→32 hidden, then 32→10 output. It generates the weight and bias ROM addresses, the input-select index, and the MAC, bias and writeback strobes. It answers a go/done handshake from the top-level feed-forward FSM. It contains no arithmetic on data, only sequencing.

---
 rtl/mlp_pkg.sv | 27 ++
 rtl/mlp_layer_sequencer_if.sv | 29 ++
 rtl/mlp_addr_gen.sv | 92 +++++++++
 rtl/mlp_layer_sequencer.sv | 101 ++++++++++
 tb/tb_mlp_layer_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_pkg.sv
// Shared constants and state encoding for the two-layer MLP MAC sequencer.
package mlp_pkg;

  localparam int IN_NR      = 196;
  localparam int HL_NEURONS = 32;
  localparam int OL_NEURONS = 10;

  localparam int OL_W_BASE = IN_NR * HL_NEURONS;
  localparam int OL_B_BASE = HL_NEURONS;

  // Per-neuron cost: CLR + fan-in MAC cycles + DRAIN + BIAS + ACT + WRITE.
  localparam int HL_NEURON_CYCLES = IN_NR + 5;
  localparam int OL_NEURON_CYCLES = HL_NEURONS + 5;
  localparam int RUN_CYCLES = HL_NEURONS * HL_NEURON_CYCLES + OL_NEURONS * OL_NEURON_CYCLES + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_MAC,
    S_DRAIN,
    S_BIAS,
    S_ACT,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/mlp_layer_sequencer_if.sv
// Handshake and datapath-control bundle between the feed-forward FSM and the layer sequencer.
interface mlp_layer_sequencer_if #(
  parameter int ADDR_W = 13
);
  logic              start;
  logic              busy;
  logic              done;
  logic              layer;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        src_idx;
  logic [5:0]        b_addr;
  logic              mac_clr;
  logic              mac_en;
  logic              bias_add;
  logic              act_wr;
  logic [5:0]        act_idx;

  modport master (
    output start,
    input  busy, done, layer, w_addr, src_idx, b_addr,
    input  mac_clr, mac_en, bias_add, act_wr, act_idx
  );

  modport slave (
    input  start,
    output busy, done, layer, w_addr, src_idx, b_addr,
    output mac_clr, mac_en, bias_add, act_wr, act_idx
  );
endinterface

// File: rtl/mlp_addr_gen.sv
// Address/index counters for the MLP sequencer: weight address, input index, neuron and layer.
module mlp_addr_gen
  import mlp_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  state_t            state,
  input  logic              launch,
  output logic              layer,
  output logic [ADDR_W-1:0] w_addr,
  output logic [7:0]        src_idx,
  output logic [5:0]        b_addr,
  output logic [5:0]        act_idx,
  output logic              in_last,
  output logic              neuron_last
);

  localparam logic [7:0]        HL_LAST_IN = 8'(IN_NR - 1);
  localparam logic [7:0]        OL_LAST_IN = 8'(HL_NEURONS - 1);
  localparam logic [5:0]        HL_LAST_N  = 6'(HL_NEURONS - 1);
  localparam logic [5:0]        OL_LAST_N  = 6'(OL_NEURONS - 1);
  localparam logic [ADDR_W-1:0] HL_STEP    = ADDR_W'(IN_NR);
  localparam logic [ADDR_W-1:0] OL_STEP    = ADDR_W'(HL_NEURONS);
  localparam logic [ADDR_W-1:0] OL_BASE    = ADDR_W'(OL_W_BASE);
  localparam logic [5:0]        B_OFS      = 6'(OL_B_BASE);

  logic [ADDR_W-1:0] w_cnt_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [7:0]        in_cnt_reg;
  logic [5:0]        neuron_reg;
  logic              layer_reg;
  logic [5:0]        b_addr_reg;
  logic [5:0]        act_idx_reg;

  assign in_last     = (in_cnt_reg == (layer_reg ? OL_LAST_IN : HL_LAST_IN));
  assign neuron_last = (neuron_reg == (layer_reg ? OL_LAST_N : HL_LAST_N));

  // base_reg walks neuron by neuron so the weight base never needs a multiplier.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_cnt_reg   <= '0;
      base_reg    <= '0;
      in_cnt_reg  <= '0;
      neuron_reg  <= '0;
      layer_reg   <= 1'b0;
      b_addr_reg  <= '0;
      act_idx_reg <= '0;
    end else begin
      if (launch) begin
        base_reg   <= '0;
        neuron_reg <= '0;
        layer_reg  <= 1'b0;
      end
      case (state)
        S_CLR: begin
          w_cnt_reg  <= base_reg;
          in_cnt_reg <= '0;
        end
        S_MAC: begin
          if (!in_last) begin
            w_cnt_reg  <= w_cnt_reg + ADDR_W'(1);
            in_cnt_reg <= in_cnt_reg + 8'd1;
          end
        end
        S_DRAIN: b_addr_reg <= layer_reg ? (B_OFS + neuron_reg) : neuron_reg;
        S_ACT:   act_idx_reg <= neuron_reg;
        S_WRITE: begin
          if (neuron_last) begin
            neuron_reg <= '0;
            if (!layer_reg) begin
              layer_reg <= 1'b1;
              base_reg  <= OL_BASE;
            end
          end else begin
            neuron_reg <= neuron_reg + 6'd1;
            base_reg   <= base_reg + (layer_reg ? OL_STEP : HL_STEP);
          end
        end
        default: ;
      endcase
    end
  end

  assign layer   = layer_reg;
  assign w_addr  = w_cnt_reg;
  assign src_idx = in_cnt_reg;
  assign b_addr  = b_addr_reg;
  assign act_idx = act_idx_reg;

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Control FSM driving one shared MAC datapath through the 196->32 and 32->10 MLP layers.
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  mlp_layer_sequencer_if.slave  bus
);

  state_t state_reg;
  state_t state_next;

  logic busy_reg;
  logic done_reg;
  logic mac_clr_reg;
  logic w_valid_reg;
  logic mac_en_reg;
  logic bias_add_reg;
  logic act_wr_reg;

  logic              launch;
  logic              in_last;
  logic              neuron_last;
  logic              layer;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        src_idx;
  logic [5:0]        b_addr;
  logic [5:0]        act_idx;

  assign launch = (state_reg == S_IDLE) && bus.start;

  mlp_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .state       (state_reg),
    .launch      (launch),
    .layer       (layer),
    .w_addr      (w_addr),
    .src_idx     (src_idx),
    .b_addr      (b_addr),
    .act_idx     (act_idx),
    .in_last     (in_last),
    .neuron_last (neuron_last)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.start) state_next = S_CLR;
      S_CLR:   state_next = S_MAC;
      S_MAC:   if (in_last) state_next = S_DRAIN;
      S_DRAIN: state_next = S_BIAS;
      S_BIAS:  state_next = S_ACT;
      S_ACT:   state_next = S_WRITE;
      S_WRITE: state_next = (neuron_last && layer) ? S_DONE : S_CLR;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with state_reg.
  // mac_en trails the address-valid cycle to match the 1-cycle ROM/mux latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      mac_clr_reg  <= 1'b0;
      w_valid_reg  <= 1'b0;
      mac_en_reg   <= 1'b0;
      bias_add_reg <= 1'b0;
      act_wr_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      busy_reg     <= (state_next != S_IDLE);
      done_reg     <= (state_next == S_DONE);
      mac_clr_reg  <= (state_next == S_CLR);
      w_valid_reg  <= (state_next == S_MAC);
      mac_en_reg   <= w_valid_reg;
      bias_add_reg <= (state_next == S_ACT);
      act_wr_reg   <= (state_next == S_WRITE);
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.layer    = layer;
  assign bus.w_addr   = w_addr;
  assign bus.src_idx  = src_idx;
  assign bus.b_addr   = b_addr;
  assign bus.mac_clr  = mac_clr_reg;
  assign bus.mac_en   = mac_en_reg;
  assign bus.bias_add = bias_add_reg;
  assign bus.act_wr   = act_wr_reg;
  assign bus.act_idx  = act_idx;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Self-checking bench for mlp_layer_sequencer: timeline checks plus an act_wr scoreboard.
module tb_mlp_layer_sequencer;
  import mlp_pkg::*;

  localparam int ADDR_W = 13;

  typedef struct {
    int         cyc;
    logic       layer;
    logic [5:0] idx;
  } act_ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   run_base = 0;
  int   checks = 0;
  int   errors = 0;
  int   act_count = 0;
  act_ev_t exp_q[$];

  mlp_layer_sequencer_if #(.ADDR_W(ADDR_W)) bus_if ();

  mlp_layer_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every act_wr pulse must match the next expected write.
  always @(negedge clk) begin : mon
    act_ev_t e;
    if (bus_if.act_wr === 1'b1) begin
      act_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL act_wr_unexpected: got act_wr at cycle %0d layer=%0d idx=%0d, required none",
                 cyc - run_base, bus_if.layer, bus_if.act_idx);
      end else begin
        e = exp_q.pop_front();
        if ((cyc - run_base) != e.cyc || bus_if.layer !== e.layer || bus_if.act_idx !== e.idx) begin
          errors++;
          $display("FAIL act_wr_event: got cycle=%0d layer=%0d idx=%0d, required cycle=%0d layer=%0d idx=%0d",
                   cyc - run_base, bus_if.layer, bus_if.act_idx, e.cyc, e.layer, e.idx);
        end else begin
          $display("act_wr cycle=%0d layer=%0d idx=%0d", e.cyc, e.layer, e.idx);
        end
      end
    end
  end

  task automatic push_run_events();
    act_ev_t e;
    for (int n = 0; n < 32; n++) begin
      e.cyc = HL_NEURON_CYCLES * (n + 1); e.layer = 1'b0; e.idx = 6'(n);
      exp_q.push_back(e);
    end
    for (int n = 0; n < 10; n++) begin
      e.cyc = 32 * HL_NEURON_CYCLES + OL_NEURON_CYCLES * (n + 1); e.layer = 1'b1; e.idx = 6'(n);
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    logic [39:0] outs;
    reset = 1'b1;
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      outs = {bus_if.busy, bus_if.done, bus_if.layer, bus_if.w_addr, bus_if.src_idx, bus_if.b_addr,
              bus_if.mac_clr, bus_if.mac_en, bus_if.bias_add, bus_if.act_wr, bus_if.act_idx};
      checks++;
      if (outs !== 40'd0) begin
        errors++;
        $display("FAIL reset_idle: got outputs=%h, required 0", outs);
      end
    end
    $display("reset idle checked for 10 cycles");
  endtask

  task automatic test_full_run(input bit hold_start);
    int   c0;
    logic exp_en;
    @(negedge clk);
    bus_if.start = 1'b1;
    run_base = cyc;
    c0 = act_count;
    push_run_events();
    for (int r = 1; r <= 6805; r++) begin
      @(negedge clk);
      bus_if.start = hold_start || (r == 500) || (r == 6433) || (r == 6803);
      if (r <= 201 || (r >= 6433 && r <= 6469)) begin
        exp_en = (r >= 3 && r <= 198) || (r >= 6435 && r <= 6466);
        checks++;
        if (bus_if.mac_en !== exp_en) begin
          errors++;
          $display("FAIL mac_en: cycle %0d got %0b, required %0b", r, bus_if.mac_en, exp_en);
        end
      end
      if (r >= 2 && r <= 197) begin
        checks++;
        if (bus_if.w_addr !== 13'(r - 2) || bus_if.src_idx !== 8'(r - 2)) begin
          errors++;
          $display("FAIL hl_addr: cycle %0d got w_addr=%0d src_idx=%0d, required %0d/%0d",
                   r, bus_if.w_addr, bus_if.src_idx, r - 2, r - 2);
        end
      end
      if (r >= 6434 && r <= 6465) begin
        checks++;
        if (bus_if.w_addr !== 13'(6272 + r - 6434) || bus_if.src_idx !== 8'(r - 6434)) begin
          errors++;
          $display("FAIL ol_addr: cycle %0d got w_addr=%0d src_idx=%0d, required %0d/%0d",
                   r, bus_if.w_addr, bus_if.src_idx, 6272 + r - 6434, r - 6434);
        end
      end
      if (r <= 6803) begin
        checks++;
        if (bus_if.layer !== (r >= 6433)) begin
          errors++;
          $display("FAIL layer: cycle %0d got %0b, required %0b", r, bus_if.layer, (r >= 6433));
        end
      end
      checks++;
      if (bus_if.done !== (r == RUN_CYCLES)) begin
        errors++;
        $display("FAIL done: cycle %0d got %0b, required %0b", r, bus_if.done, (r == RUN_CYCLES));
      end
      case (r)
        1, 202, 6433: begin
          checks++;
          if (bus_if.mac_clr !== 1'b1 || bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL mac_clr: cycle %0d got mac_clr=%0b busy=%0b, required 1/1", r, bus_if.mac_clr, bus_if.busy);
          end
        end
        199, 6467: begin
          checks++;
          if (bus_if.b_addr !== ((r == 199) ? 6'd0 : 6'd32)) begin
            errors++;
            $display("FAIL b_addr: cycle %0d got %0d, required %0d", r, bus_if.b_addr, (r == 199) ? 0 : 32);
          end
        end
        200: begin
          checks++;
          if (bus_if.bias_add !== 1'b1) begin
            errors++;
            $display("FAIL bias_add: cycle 200 got %0b, required 1", bus_if.bias_add);
          end
        end
        203: begin
          checks++;
          if (bus_if.w_addr !== 13'd196) begin
            errors++;
            $display("FAIL w_addr_n1: cycle 203 got %0d, required 196", bus_if.w_addr);
          end
        end
        6803, 6804: begin
          checks++;
          if (bus_if.busy !== (r == 6803)) begin
            errors++;
            $display("FAIL busy_end: cycle %0d got %0b, required %0b", r, bus_if.busy, (r == 6803));
          end
        end
        6805: begin
          checks++;
          if (bus_if.busy !== hold_start || bus_if.mac_clr !== hold_start) begin
            errors++;
            $display("FAIL relaunch: cycle 6805 got busy=%0b mac_clr=%0b, required %0b/%0b",
                     bus_if.busy, bus_if.mac_clr, hold_start, hold_start);
          end
        end
        default: ;
      endcase
    end
    bus_if.start = 1'b0;
    checks++;
    if (act_count - c0 != 42 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL act_wr_total: got %0d writes (%0d pending), required 42 (0 pending)",
               act_count - c0, exp_q.size());
    end
    $display("run finished hold_start=%0b writes=%0d", hold_start, act_count - c0);
  endtask

  task automatic test_reset_mid_run();
    int          c0;
    logic [39:0] outs;
    @(negedge clk);
    bus_if.start = 1'b1;
    run_base = cyc;
    c0 = act_count;
    push_run_events();
    for (int r = 1; r <= 1040; r++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      reset = (r == 1000);
      if (r == 1001) begin
        exp_q.delete();
        outs = {bus_if.busy, bus_if.done, bus_if.layer, bus_if.w_addr, bus_if.src_idx, bus_if.b_addr,
                bus_if.mac_clr, bus_if.mac_en, bus_if.bias_add, bus_if.act_wr, bus_if.act_idx};
        checks++;
        if (outs !== 40'd0) begin
          errors++;
          $display("FAIL midrun_reset: got outputs=%h, required 0", outs);
        end
        checks++;
        if (act_count - c0 != 4) begin
          errors++;
          $display("FAIL midrun_writes: got %0d writes before reset, required 4", act_count - c0);
        end
      end
      if (r > 1001) begin
        checks++;
        if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
          errors++;
          $display("FAIL midrun_quiet: cycle %0d got done=%0b busy=%0b, required 0/0", r, bus_if.done, bus_if.busy);
        end
      end
    end
    $display("mid-run reset checked");
  endtask

  task automatic test_back_to_back();
    test_full_run(1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.act_wr !== 1'b0) begin
      errors++;
      $display("FAIL b2b_abort: got busy=%0b act_wr=%0b, required 0/0", bus_if.busy, bus_if.act_wr);
    end
    $display("back-to-back relaunch checked");
  endtask

  initial begin
    bus_if.start = 1'b0;
    test_reset();
    test_full_run(1'b0);
    test_reset_mid_run();
    test_full_run(1'b0);
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
